// File: rtl/fmap_out_serializer.sv
// Buffers 16-lane feature-map vectors in a small FIFO and emits them one word per cycle with lane/col/row tags.
// Optional build macro OUT_SER_RELU_EN clamps negative serialized words to zero.
module fmap_out_serializer #(
    parameter int LANES = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int COLS  = 3,
    parameter int ROWS  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [LANES*DW-1:0]      in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(LANES)-1:0] out_lane,
    output logic [$clog2(COLS)-1:0]  out_col,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     overflow
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int EW = LANES * DW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [NW-1:0] count, count_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          overflow_q;
    logic [EW-1:0] head;
    logic          head_sof;
    logic [DW-1:0] head_word;
    logic          accept, last_lane, pop_last, push;

    function automatic logic [DW-1:0] shape_word(input logic signed [DW-1:0] w);
`ifdef OUT_SER_RELU_EN
        shape_word = w[DW-1] ? '0 : w;
`else
        shape_word = w;
`endif
    endfunction

    assign head      = mem[rptr];
    assign head_sof  = head[EW-1];
    assign head_word = head[int'(lane_q)*DW +: DW];

    // A sof vector restarts the frame; otherwise the vector takes the tags left by the last pop.
    assign cur_col   = head_sof ? '0 : col_q;
    assign cur_row   = head_sof ? '0 : row_q;

    assign accept    = out_valid && out_ready;
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign pop_last  = accept && last_lane;
    assign push      = in_valid && ((count < NW'(DEPTH)) || pop_last);
    assign count_d   = count + NW'(push) - NW'(pop_last);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d = SEND;
                    lane_d  = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    if (last_lane) begin
                        lane_d = '0;
                        if (count_d == '0) state_d = IDLE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pop_last) begin
            if (cur_col == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            col_q   <= col_d;
            row_q   <= row_d;
            count   <= count_d;
            if (push)
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop_last)
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            if (in_valid && !push)
                overflow_q <= 1'b1;
        end
    end

    // Storage carries no reset: occupancy is governed solely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {in_sof, in_data};
    end

    assign in_ready  = (count < NW'(DEPTH));
    assign overflow  = overflow_q;
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? shape_word(head_word) : '0;
    assign out_lane  = out_valid ? lane_q : '0;
    assign out_col   = out_valid ? cur_col : '0;
    assign out_row   = out_valid ? cur_row : '0;
    assign out_sof   = out_valid && head_sof && (lane_q == '0);
    assign out_eol   = out_valid && last_lane && (cur_col == CW'(COLS - 1));
    assign out_eof   = out_eol && (cur_row == RW'(ROWS - 1));
endmodule
